hdmi_clken_gen: RTL and testbench

//  Lock-qualified reset sequencer plus NUM_CH fractional clock-enable generators, all on the PLL pixel clock.

---
 rtl/hdmi_clk_pkg.sv | 24 ++
 rtl/hdmi_frac_ce.sv | 56 +++++
 rtl/hdmi_clken_gen.sv | 132 +++++++++++++
 tb/tb_hdmi_clken_gen.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_clk_pkg.sv
// Shared FSM encoding, ratio constants and helpers for the HDMI clock-enable generator.
package hdmi_clk_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABILISE = 2'd1,
      RUN       = 2'd2
   } state_e;

   // 25.2 MHz pixel clock * 1/525 = 48 kHz audio tick
   localparam int AUDIO48K_NUM = 1;
   localparam int AUDIO48K_DEN = 525;

   localparam logic [7:0] LOCK_CNT_MAX = 8'd255;

   function automatic int ch_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == LOCK_CNT_MAX) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/hdmi_frac_ce.sv
// One fractional clock-enable channel: NUM/DEN ratio, phase accumulator and registered strobe.
module hdmi_frac_ce
   import hdmi_clk_pkg::*;
#(
   parameter int ACC_W = 24
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_run,
   input  logic             i_clr,
   input  logic             i_load,
   input  logic [ACC_W-1:0] i_num,
   input  logic [ACC_W-1:0] i_den,
   output logic             o_ce
);

   logic [ACC_W-1:0] r_num;
   logic [ACC_W-1:0] r_den;
   logic [ACC_W-1:0] r_acc;
   logic             r_ce;
   logic [ACC_W:0]   w_sum;
   logic             w_hit;
   logic [ACC_W-1:0] w_acc_nxt;

   // acc < DEN and NUM <= DEN keep the sum below 2*DEN, so the remainder always fits ACC_W
   always_comb begin
      w_sum     = {1'b0, r_acc} + {1'b0, r_num};
      w_hit     = (w_sum >= {1'b0, r_den});
      w_acc_nxt = w_hit ? ACC_W'(w_sum - {1'b0, r_den}) : ACC_W'(w_sum);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_num <= '0;
         r_den <= ACC_W'(1);
         r_acc <= '0;
         r_ce  <= 1'b0;
      end else if (i_load) begin
         r_num <= i_num;
         r_den <= i_den;
         r_acc <= '0;
         r_ce  <= 1'b0;
      end else if (i_clr) begin
         r_acc <= '0;
         r_ce  <= 1'b0;
      end else if (i_run) begin
         r_acc <= w_acc_nxt;
         r_ce  <= w_hit;
      end else begin
         r_ce  <= 1'b0;
      end
   end

   assign o_ce = r_ce;

endmodule

// File: rtl/hdmi_clken_gen.sv
// Lock-qualified reset sequencer and NUM_CH fractional clock-enable generators on the PLL pixel clock.
module hdmi_clken_gen
   import hdmi_clk_pkg::*;
#(
   parameter int  NUM_CH      = 2,
   parameter int  ACC_W       = 24,
   parameter int  LOCK_CYCLES = 1024,
   localparam int CH_W        = ch_idx_w(NUM_CH)
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              pll_locked,
   input  logic              cfg_wr,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [ACC_W-1:0]  cfg_num,
   input  logic [ACC_W-1:0]  cfg_den,
   output logic              cfg_ack,
   output logic              cfg_err,
   output logic [NUM_CH-1:0] ce,
   output logic              rst_out,
   output logic              ready,
   output logic [7:0]        lock_lost_cnt
);

   localparam int                CNT_W    = $clog2(LOCK_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
   localparam logic [CH_W:0]     CH_LIMIT = (CH_W + 1)'(NUM_CH);

   logic              r_sync1;
   logic              r_lk;
   state_e            r_state;
   state_e            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic              w_run_adv;
   logic              w_lock_loss;
   logic              w_cfg_bad;
   logic              w_cfg_ok;
   logic [NUM_CH-1:0] w_load;
   logic              r_cfg_ack;
   logic              r_cfg_err;
   logic [7:0]        r_lost;

   // Two-flop synchroniser for the asynchronous PLL lock
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_lk    <= 1'b0;
      end else begin
         r_sync1 <= pll_locked;
         r_lk    <= r_sync1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= WAIT_LOCK;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_run_adv   = 1'b0;
      w_lock_loss = 1'b0;
      case (r_state)
         WAIT_LOCK: begin
            if (r_lk) w_state_nxt = STABILISE;
         end
         STABILISE: begin
            if (!r_lk)                  w_state_nxt = WAIT_LOCK;
            else if (r_cnt == CNT_LAST) w_state_nxt = RUN;
         end
         RUN: begin
            if (!r_lk) begin
               w_state_nxt = WAIT_LOCK;
               w_lock_loss = 1'b1;
            end else begin
               w_run_adv   = 1'b1;
            end
         end
         default: w_state_nxt = WAIT_LOCK;
      endcase
   end

   // Stability counter only advances in STABILISE; every entry starts it from zero
   always_ff @(posedge clk) begin
      if (rst)                        r_cnt <= '0;
      else if (r_state == STABILISE)  r_cnt <= r_cnt + CNT_W'(1);
      else                            r_cnt <= '0;
   end

   always_comb begin
      w_cfg_bad = (cfg_den == '0) || (cfg_num > cfg_den) || ({1'b0, cfg_ch} >= CH_LIMIT);
      w_cfg_ok  = cfg_wr && !w_cfg_bad;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cfg_ack <= 1'b0;
         r_cfg_err <= 1'b0;
         r_lost    <= '0;
      end else begin
         r_cfg_ack <= cfg_wr;
         r_cfg_err <= cfg_wr && w_cfg_bad;
         if (w_lock_loss) r_lost <= sat_inc8(r_lost);
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      localparam logic [CH_W-1:0] IDX = CH_W'(g);

      assign w_load[g] = w_cfg_ok && (cfg_ch == IDX);

      hdmi_frac_ce #(
         .ACC_W (ACC_W)
      ) u_frac_ce (
         .clk    (clk),
         .rst    (rst),
         .i_run  (w_run_adv),
         .i_clr  (w_lock_loss),
         .i_load (w_load[g]),
         .i_num  (cfg_num),
         .i_den  (cfg_den),
         .o_ce   (ce[g])
      );
   end

   assign cfg_ack       = r_cfg_ack;
   assign cfg_err       = r_cfg_err;
   assign rst_out       = (r_state != RUN);
   assign ready         = (r_state == RUN);
   assign lock_lost_cnt = r_lost;

endmodule

// File: tb/tb_hdmi_clken_gen.sv
// Scoreboard bench for hdmi_clken_gen: lock sequencing, ratio strobes, config handling, lock-loss counting.
module tb_hdmi_clken_gen;

   localparam int NUM_CH      = 3;
   localparam int ACC_W       = 24;
   localparam int LOCK_CYCLES = 16;
   localparam int CH_W        = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              pll_locked = 1'b0;
   logic              cfg_wr = 1'b0;
   logic [CH_W-1:0]   cfg_ch = '0;
   logic [ACC_W-1:0]  cfg_num = '0;
   logic [ACC_W-1:0]  cfg_den = '0;
   logic              cfg_ack;
   logic              cfg_err;
   logic [NUM_CH-1:0] ce;
   logic              rst_out;
   logic              ready;
   logic [7:0]        lock_lost_cnt;

   hdmi_clken_gen #(
      .NUM_CH      (NUM_CH),
      .ACC_W       (ACC_W),
      .LOCK_CYCLES (LOCK_CYCLES)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .pll_locked    (pll_locked),
      .cfg_wr        (cfg_wr),
      .cfg_ch        (cfg_ch),
      .cfg_num       (cfg_num),
      .cfg_den       (cfg_den),
      .cfg_ack       (cfg_ack),
      .cfg_err       (cfg_err),
      .ce            (ce),
      .rst_out       (rst_out),
      .ready         (ready),
      .lock_lost_cnt (lock_lost_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   int m_num   [NUM_CH];
   int m_den   [NUM_CH];
   int m_start [NUM_CH];

   typedef struct {
      int ch;
      int cyc;
   } exp_t;
   exp_t sbq[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input int ch, input int num, input int den);
      cfg_ch  = CH_W'(ch);
      cfg_num = ACC_W'(num);
      cfg_den = ACC_W'(den);
      cfg_wr  = 1'b1;
      tick();
      cfg_wr  = 1'b0;
   endtask

   task automatic model_write(input int ch, input int num, input int den);
      m_num[ch]   = num;
      m_den[ch]   = den;
      m_start[ch] = cyc;
   endtask

   task automatic model_reset();
      for (int k = 0; k < NUM_CH; k++) begin
         m_num[k]   = 0;
         m_den[k]   = 1;
         m_start[k] = 0;
      end
   endtask

   task automatic model_restart(input int c);
      for (int k = 0; k < NUM_CH; k++) m_start[k] = c;
   endtask

   // A pulse is due on the n-th enabled edge whenever floor(NUM*n/DEN) steps up
   task automatic push_expect(input int from, input int to);
      exp_t   e;
      longint n, a, b;
      sbq.delete();
      for (int c = from + 1; c <= to; c++) begin
         for (int k = 0; k < NUM_CH; k++) begin
            n = longint'(c - m_start[k]);
            if (m_num[k] != 0 && n >= 1) begin
               a = (longint'(m_num[k]) * n) / longint'(m_den[k]);
               b = (longint'(m_num[k]) * (n - 1)) / longint'(m_den[k]);
               if (a > b) begin
                  e.ch  = k;
                  e.cyc = c;
                  sbq.push_back(e);
               end
            end
         end
      end
   endtask

   task automatic wait_ready(input int lim, output bit ok, output int rc);
      ok = 1'b0;
      rc = 0;
      for (int i = 0; i < lim && !ok; i++) begin
         tick();
         if (ready === 1'b1) begin
            ok = 1'b1;
            rc = cyc;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      pll_locked = 1'b0;
      cfg_ch = 2'd0; cfg_num = ACC_W'(1); cfg_den = ACC_W'(2); cfg_wr = 1'b1;
      tick(); tick();
      cfg_wr = 1'b0;
      model_reset();
      checks++;
      if (ready !== 1'b0 || rst_out !== 1'b1) begin
         errors++; $display("FAIL reset_state ready/rst_out got %b/%b want 0/1", ready, rst_out);
      end
      checks++;
      if (ce !== 3'b000 || lock_lost_cnt !== 8'd0) begin
         errors++; $display("FAIL reset_outputs ce/lost got %b/%0d want 000/0", ce, lock_lost_cnt);
      end
      checks++;
      if (cfg_ack !== 1'b0 || cfg_err !== 1'b0) begin
         errors++; $display("FAIL reset_cfg ack/err got %b/%b want 0/0", cfg_ack, cfg_err);
      end
   endtask

   task automatic test_glitch();
      rst = 1'b0;
      pll_locked = 1'b1;
      repeat (8) tick();
      pll_locked = 1'b0;
      tick();
      pll_locked = 1'b1;
      tick();
      repeat (17) tick();
      checks++;
      if (ready !== 1'b0 || lock_lost_cnt !== 8'd0) begin
         errors++; $display("FAIL glitch_delay ready/lost got %b/%0d want 0/0", ready, lock_lost_cnt);
      end
      tick();
      checks++;
      if (ready !== 1'b1 || rst_out !== 1'b0 || lock_lost_cnt !== 8'd0) begin
         errors++; $display("FAIL glitch_run ready/rst_out/lost got %b/%b/%0d want 1/0/0", ready, rst_out, lock_lost_cnt);
      end
   endtask

   task automatic test_lock_latency();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      model_reset();
      tick();
      repeat (17) tick();
      checks++;
      if (ready !== 1'b0 || rst_out !== 1'b1) begin
         errors++; $display("FAIL latency_n17 ready/rst_out got %b/%b want 0/1", ready, rst_out);
      end
      tick();
      checks++;
      if (ready !== 1'b1 || rst_out !== 1'b0 || lock_lost_cnt !== 8'd0) begin
         errors++; $display("FAIL latency_n18 ready/rst_out/lost got %b/%b/%0d want 1/0/0", ready, rst_out, lock_lost_cnt);
      end
   endtask

   task automatic test_ratio();
      bit exp_b;
      int cnt0 = 0, cnt1 = 0, cnt1_700 = 0;
      cfg_write(0, 1, 525);
      checks++;
      if (cfg_ack !== 1'b1 || cfg_err !== 1'b0) begin
         errors++; $display("FAIL ratio_ack0 ack/err got %b/%b want 1/0", cfg_ack, cfg_err);
      end
      model_write(0, 1, 525);
      cfg_write(1, 3, 7);
      checks++;
      if (cfg_ack !== 1'b1 || cfg_err !== 1'b0) begin
         errors++; $display("FAIL ratio_ack1 ack/err got %b/%b want 1/0", cfg_ack, cfg_err);
      end
      model_write(1, 3, 7);
      push_expect(cyc, cyc + 52500);
      for (int i = 1; i <= 52500; i++) begin
         tick();
         if (ce[0]) cnt0++;
         if (ce[1]) cnt1++;
         if (ce[1] && i <= 700) cnt1_700++;
         for (int k = 0; k < NUM_CH; k++) begin
            exp_b = (sbq.size() > 0) && (sbq[0].cyc == cyc) && (sbq[0].ch == k);
            if (exp_b) void'(sbq.pop_front());
            if (ce[k] || exp_b) begin
               checks++;
               if (ce[k] !== exp_b) begin
                  errors++; $display("FAIL ratio_ce%0d cyc %0d got %b want %b", k, cyc, ce[k], exp_b);
               end
            end
         end
      end
      checks++;
      if (cnt0 !== 100) begin
         errors++; $display("FAIL ratio_count0 got %0d want 100", cnt0);
      end
      checks++;
      if (cnt1_700 !== 300 || cnt1 !== 22500) begin
         errors++; $display("FAIL ratio_count1 got %0d/%0d want 300/22500", cnt1_700, cnt1);
      end
      checks++;
      if (sbq.size() !== 0) begin
         errors++; $display("FAIL ratio_pending got %0d want 0", sbq.size());
      end
   endtask

   task automatic test_cfg_reject();
      bit exp_b;
      int bad_ch [3] = '{0, 0, 3};
      int bad_nm [3] = '{5, 5, 1};
      int bad_dn [3] = '{4, 0, 2};
      for (int j = 0; j < 3; j++) begin
         cfg_write(bad_ch[j], bad_nm[j], bad_dn[j]);
         checks++;
         if (cfg_ack !== 1'b1 || cfg_err !== 1'b1) begin
            errors++; $display("FAIL reject%0d ack/err got %b/%b want 1/1", j, cfg_ack, cfg_err);
         end
      end
      tick();
      checks++;
      if (cfg_ack !== 1'b0 || cfg_err !== 1'b0) begin
         errors++; $display("FAIL ack_pulse ack/err got %b/%b want 0/0", cfg_ack, cfg_err);
      end
      push_expect(cyc, cyc + 1000);
      for (int i = 0; i < 1000; i++) begin
         tick();
         for (int k = 0; k < NUM_CH; k++) begin
            exp_b = (sbq.size() > 0) && (sbq[0].cyc == cyc) && (sbq[0].ch == k);
            if (exp_b) void'(sbq.pop_front());
            if (ce[k] || exp_b) begin
               checks++;
               if (ce[k] !== exp_b) begin
                  errors++; $display("FAIL reject_ce%0d cyc %0d got %b want %b", k, cyc, ce[k], exp_b);
               end
            end
         end
      end
   endtask

   task automatic test_realign();
      bit exp_b;
      cfg_write(1, 5, 11);
      checks++;
      if (cfg_ack !== 1'b1 || cfg_err !== 1'b0 || ce[1] !== 1'b0) begin
         errors++; $display("FAIL realign_wr ack/err/ce1 got %b/%b/%b want 1/0/0", cfg_ack, cfg_err, ce[1]);
      end
      model_write(1, 5, 11);
      push_expect(cyc, cyc + 500);
      for (int i = 0; i < 500; i++) begin
         tick();
         for (int k = 0; k < NUM_CH; k++) begin
            exp_b = (sbq.size() > 0) && (sbq[0].cyc == cyc) && (sbq[0].ch == k);
            if (exp_b) void'(sbq.pop_front());
            if (ce[k] || exp_b) begin
               checks++;
               if (ce[k] !== exp_b) begin
                  errors++; $display("FAIL realign_ce%0d cyc %0d got %b want %b", k, cyc, ce[k], exp_b);
               end
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      cfg_write(0, 9, 9);
      checks++;
      if (cfg_ack !== 1'b1 || cfg_err !== 1'b0) begin
         errors++; $display("FAIL b2b_0 ack/err got %b/%b want 1/0", cfg_ack, cfg_err);
      end
      model_write(0, 9, 9);
      cfg_write(2, 0, 5);
      checks++;
      if (cfg_ack !== 1'b1 || cfg_err !== 1'b0) begin
         errors++; $display("FAIL b2b_1 ack/err got %b/%b want 1/0", cfg_ack, cfg_err);
      end
      model_write(2, 0, 5);
      cfg_write(1, 7, 3);
      checks++;
      if (cfg_ack !== 1'b1 || cfg_err !== 1'b1) begin
         errors++; $display("FAIL b2b_2 ack/err got %b/%b want 1/1", cfg_ack, cfg_err);
      end
   endtask

   task automatic test_full_zero();
      bit exp_b;
      int cnt0 = 0;
      push_expect(cyc, cyc + 100);
      for (int i = 0; i < 100; i++) begin
         tick();
         if (ce[0]) cnt0++;
         for (int k = 0; k < NUM_CH; k++) begin
            exp_b = (sbq.size() > 0) && (sbq[0].cyc == cyc) && (sbq[0].ch == k);
            if (exp_b) void'(sbq.pop_front());
            if (ce[k] || exp_b) begin
               checks++;
               if (ce[k] !== exp_b) begin
                  errors++; $display("FAIL fullzero_ce%0d cyc %0d got %b want %b", k, cyc, ce[k], exp_b);
               end
            end
         end
      end
      checks++;
      if (cnt0 !== 100) begin
         errors++; $display("FAIL full_rate got %0d want 100", cnt0);
      end
   endtask

   task automatic test_lock_drop();
      bit exp_b;
      bit ok;
      int rc;
      pll_locked = 1'b0;
      tick(); tick();
      checks++;
      if (ready !== 1'b1 || ce[0] !== 1'b1) begin
         errors++; $display("FAIL drop_pre ready/ce0 got %b/%b want 1/1", ready, ce[0]);
      end
      tick();
      checks++;
      if (ready !== 1'b0 || rst_out !== 1'b1 || ce !== 3'b000 || lock_lost_cnt !== 8'd1) begin
         errors++; $display("FAIL drop_post ready/rst_out/ce/lost got %b/%b/%b/%0d want 0/1/000/1",
                            ready, rst_out, ce, lock_lost_cnt);
      end
      pll_locked = 1'b1;
      wait_ready(40, ok, rc);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL drop_relock ready got 0 want 1 within 40 cycles");
      end
      model_restart(rc);
      push_expect(cyc, cyc + 200);
      for (int i = 0; i < 200; i++) begin
         tick();
         for (int k = 0; k < NUM_CH; k++) begin
            exp_b = (sbq.size() > 0) && (sbq[0].cyc == cyc) && (sbq[0].ch == k);
            if (exp_b) void'(sbq.pop_front());
            if (ce[k] || exp_b) begin
               checks++;
               if (ce[k] !== exp_b) begin
                  errors++; $display("FAIL relock_ce%0d cyc %0d got %b want %b", k, cyc, ce[k], exp_b);
               end
            end
         end
      end
   endtask

   task automatic test_saturate();
      bit ok;
      int rc;
      for (int i = 0; i < 256; i++) begin
         pll_locked = 1'b0;
         repeat (3) tick();
         pll_locked = 1'b1;
         wait_ready(40, ok, rc);
         checks++;
         if (!ok) begin
            errors++; $display("FAIL sat_relock%0d ready got 0 want 1 within 40 cycles", i);
         end
         if (i == 253) begin
            checks++;
            if (lock_lost_cnt !== 8'd255) begin
               errors++; $display("FAIL sat_255 got %0d want 255", lock_lost_cnt);
            end
         end
      end
      checks++;
      if (lock_lost_cnt !== 8'd255) begin
         errors++; $display("FAIL sat_257 got %0d want 255", lock_lost_cnt);
      end
   endtask

   task automatic test_rst_midrun();
      bit exp_b;
      bit ok;
      int rc;
      tick();
      checks++;
      if (ready !== 1'b1 || ce[0] !== 1'b1) begin
         errors++; $display("FAIL midrun_pre ready/ce0 got %b/%b want 1/1", ready, ce[0]);
      end
      rst = 1'b1;
      tick();
      checks++;
      if (ready !== 1'b0 || rst_out !== 1'b1 || ce !== 3'b000 || lock_lost_cnt !== 8'd0 ||
          cfg_ack !== 1'b0 || cfg_err !== 1'b0) begin
         errors++; $display("FAIL midrun_rst ready/rst_out/ce/lost/ack/err got %b/%b/%b/%0d/%b/%b want 0/1/000/0/0/0",
                            ready, rst_out, ce, lock_lost_cnt, cfg_ack, cfg_err);
      end
      rst = 1'b0;
      model_reset();
      wait_ready(40, ok, rc);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL midrun_relock ready got 0 want 1 within 40 cycles");
      end
      model_restart(rc);
      push_expect(cyc, cyc + 50);
      for (int i = 0; i < 50; i++) begin
         tick();
         for (int k = 0; k < NUM_CH; k++) begin
            exp_b = (sbq.size() > 0) && (sbq[0].cyc == cyc) && (sbq[0].ch == k);
            if (exp_b) void'(sbq.pop_front());
            if (ce[k] || exp_b) begin
               checks++;
               if (ce[k] !== exp_b) begin
                  errors++; $display("FAIL midrun_ce%0d cyc %0d got %b want %b", k, cyc, ce[k], exp_b);
               end
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_lock_latency();
      test_ratio();
      test_cfg_reject();
      test_realign();
      test_back_to_back();
      test_full_zero();
      test_lock_drop();
      test_saturate();
      test_rst_midrun();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
